// File: rtl/local_ni.sv
// Local network interface: credit-gated core->router injection, buffered router->core ejection.
// Latency: core write to inj_valid_o is 2 cycles with credit available; ejection head is visible in the cycle after the write.
// Backpressure: core_ready_o drops when the injection FIFO is full; ejection overflow drops the flit and sets err_o.
//
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   core_data_i/valid_i/ready_o      core -> injection FIFO (valid/ready)
//   inj_flit_o/valid_o, credit_i     injection FIFO -> router local input (credit flow control)
//   ej_flit_i/valid_i, ej_credit_o   router local output -> ejection FIFO (credit flow control)
//   core_data_o/valid_o/ready_i      ejection FIFO -> core (valid/ready)
//   err_o                            sticky protocol error (credit overflow or ejection overflow)

// Small synchronous FIFO with a combinational head and a full-width occupancy count.
// A write while full is only legal together with a pop; callers guard wr_i accordingly.
module local_ni_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       rd_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointers are exactly log2(DEPTH) bits so they wrap modulo depth for free;
  // the count carries one extra bit so full and empty never alias.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_i) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_i && !rd_i)      cnt_d = cnt_q + CW'(1);
    else if (!wr_i && rd_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset: an empty FIFO never exposes it as valid.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;
endmodule

module local_ni #(
  parameter int FLIT_W    = 32,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CREDITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] core_data_i,
  input  logic              core_valid_i,
  output logic              core_ready_o,
  output logic [FLIT_W-1:0] inj_flit_o,
  output logic              inj_valid_o,
  input  logic              credit_i,
  input  logic [FLIT_W-1:0] ej_flit_i,
  input  logic              ej_valid_i,
  output logic              ej_credit_o,
  output logic [FLIT_W-1:0] core_data_o,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  output logic              err_o
);
  localparam int INJ_CW = $clog2(INJ_DEPTH) + 1;
  localparam int EJ_CW  = $clog2(EJ_DEPTH) + 1;
  localparam logic [3:0] CRED_INIT = 4'(CREDITS);

  // ---------------- injection path ----------------
  logic              inj_wr, inj_send;
  logic [FLIT_W-1:0] inj_head;
  logic [INJ_CW-1:0] inj_cnt;
  logic [3:0]        cred_q, cred_d;
  logic              cred_err;
  logic              inj_valid_q, inj_valid_d;
  logic [FLIT_W-1:0] inj_flit_q, inj_flit_d;

  // Ready depends only on the registered count, never on same-cycle pops.
  assign core_ready_o = (inj_cnt < INJ_CW'(INJ_DEPTH));
  assign inj_wr       = core_valid_i && core_ready_o;
  assign inj_send     = (inj_cnt != '0) && (cred_q != 4'd0);

  local_ni_fifo #(.W(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (inj_wr),
    .wr_dat_i (core_data_i),
    .rd_i     (inj_send),
    .head_o   (inj_head),
    .cnt_o    (inj_cnt)
  );

  // A returned credit and a send in the same cycle cancel. A credit arriving
  // with the counter already full is a router protocol error and is ignored.
  always_comb begin
    cred_d   = cred_q;
    cred_err = 1'b0;
    if (credit_i && !inj_send) begin
      if (cred_q == CRED_INIT) cred_err = 1'b1;
      else                     cred_d   = cred_q + 4'd1;
    end else if (!credit_i && inj_send) begin
      cred_d = cred_q - 4'd1;
    end
  end

  // The outgoing flit register holds its last value between pulses.
  always_comb begin
    inj_valid_d = inj_send;
    inj_flit_d  = inj_flit_q;
    if (inj_send) inj_flit_d = inj_head;
  end

  // ---------------- ejection path ----------------
  logic              ej_pop, ej_full, ej_wr, ej_drop;
  logic [EJ_CW-1:0]  ej_cnt;
  logic              ej_credit_q, ej_credit_d;
  logic              err_q, err_d;

  assign core_valid_o = (ej_cnt != '0);
  assign ej_pop       = core_valid_o && core_ready_i;
  assign ej_full      = (ej_cnt == EJ_CW'(EJ_DEPTH));
  // A full FIFO can still take a flit when its head leaves in the same cycle.
  assign ej_wr        = ej_valid_i && (!ej_full || ej_pop);
  assign ej_drop      = ej_valid_i && ej_full && !ej_pop;

  local_ni_fifo #(.W(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_i     (ej_wr),
    .wr_dat_i (ej_flit_i),
    .rd_i     (ej_pop),
    .head_o   (core_data_o),
    .cnt_o    (ej_cnt)
  );

  always_comb begin
    ej_credit_d = ej_pop;
    err_d       = err_q || cred_err || ej_drop;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cred_q      <= CRED_INIT;
      inj_valid_q <= 1'b0;
      inj_flit_q  <= '0;
      ej_credit_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cred_q      <= cred_d;
      inj_valid_q <= inj_valid_d;
      inj_flit_q  <= inj_flit_d;
      ej_credit_q <= ej_credit_d;
      err_q       <= err_d;
    end
  end

  assign inj_valid_o = inj_valid_q;
  assign inj_flit_o  = inj_flit_q;
  assign ej_credit_o = ej_credit_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_local_ni.sv
// Self-checking bench for local_ni: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_local_ni;
  localparam int W  = 32;
  localparam int ID = 4;
  localparam int ED = 4;
  localparam int CR = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] core_data_i;
  logic         core_valid_i;
  logic         core_ready_o;
  logic [W-1:0] inj_flit_o;
  logic         inj_valid_o;
  logic         credit_i;
  logic [W-1:0] ej_flit_i;
  logic         ej_valid_i;
  logic         ej_credit_o;
  logic [W-1:0] core_data_o;
  logic         core_valid_o;
  logic         core_ready_i;
  logic         err_o;

  local_ni #(.FLIT_W(W), .INJ_DEPTH(ID), .EJ_DEPTH(ED), .CREDITS(CR)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_i  (core_data_i),
    .core_valid_i (core_valid_i),
    .core_ready_o (core_ready_o),
    .inj_flit_o   (inj_flit_o),
    .inj_valid_o  (inj_valid_o),
    .credit_i     (credit_i),
    .ej_flit_i    (ej_flit_i),
    .ej_valid_i   (ej_valid_i),
    .ej_credit_o  (ej_credit_o),
    .core_data_o  (core_data_o),
    .core_valid_o (core_valid_o),
    .core_ready_i (core_ready_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dut_sends = 0;
  int dut_ejcr  = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_inj[$];
  logic [W-1:0] m_ej[$];
  int           m_cred;
  bit           m_inj_v;
  logic [W-1:0] m_flit;
  bit           m_ejcr;
  bit           m_err;

  task automatic model_reset();
    m_inj.delete();
    m_ej.delete();
    m_cred  = CR;
    m_inj_v = 1'b0;
    m_flit  = '0;
    m_ejcr  = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge worth of behaviour, from the rules of the block.
  task automatic model_step(bit cv, logic [W-1:0] cd, bit cr, bit ev, logic [W-1:0] ed, bit crdy);
    bit ready = (m_inj.size() < ID);
    bit send  = (m_inj.size() > 0) && (m_cred > 0);
    bit pop   = (m_ej.size() > 0) && crdy;
    int ej_n  = m_ej.size();
    m_inj_v = send;
    if (send) begin
      m_flit = m_inj[0];
      m_inj.delete(0);
    end
    if (cv && ready) m_inj.push_back(cd);
    if (cr && !send && m_cred == CR) m_err = 1'b1;
    else m_cred = m_cred + int'(cr) - int'(send);
    if (pop) m_ej.delete(0);
    if (ev) begin
      if (ej_n < ED || pop) m_ej.push_back(ed);
      else m_err = 1'b1;
    end
    m_ejcr = pop;
  endtask

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".inj_valid"},  inj_valid_o,  m_inj_v);
    chk({tag, ".inj_flit"},   inj_flit_o,   m_flit);
    chk({tag, ".core_ready"}, core_ready_o, (m_inj.size() < ID));
    chk({tag, ".core_valid"}, core_valid_o, (m_ej.size() > 0));
    if (m_ej.size() > 0) chk({tag, ".core_data"}, core_data_o, m_ej[0]);
    chk({tag, ".ej_credit"},  ej_credit_o,  m_ejcr);
    chk({tag, ".err"},        err_o,        m_err);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".inj_valid"},  inj_valid_o,  0);
    chk({tag, ".inj_flit"},   inj_flit_o,   0);
    chk({tag, ".ej_credit"},  ej_credit_o,  0);
    chk({tag, ".err"},        err_o,        0);
    chk({tag, ".core_valid"}, core_valid_o, 0);
    chk({tag, ".core_ready"}, core_ready_o, 1);
  endtask

  // Entered and left on a falling edge.
  task automatic cyc(bit cv, logic [W-1:0] cd, bit cr, bit ev, logic [W-1:0] ed, bit crdy);
    core_valid_i = cv;
    core_data_i  = cd;
    credit_i     = cr;
    ej_valid_i   = ev;
    ej_flit_i    = ed;
    core_ready_i = crdy;
    model_step(cv, cd, cr, ev, ed, crdy);
    @(negedge clk);
    if (inj_valid_o) dut_sends++;
    if (ej_credit_o) dut_ejcr++;
  endtask

  task automatic idle_inputs();
    core_valid_i = 1'b0; core_data_i = '0; credit_i = 1'b0;
    ej_valid_i   = 1'b0; ej_flit_i   = '0; core_ready_i = 1'b0;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_reset(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         cv;
    logic [W-1:0] cd;
    logic         cr;
    logic         e_v;
    logic [W-1:0] e_f;
    logic         e_rdy;
  } vec_t;

  function automatic vec_t mk(logic cv, logic [W-1:0] cd, logic cr, logic e_v, logic [W-1:0] e_f, logic e_rdy);
    vec_t v;
    v.cv = cv; v.cd = cd; v.cr = cr; v.e_v = e_v; v.e_f = e_f; v.e_rdy = e_rdy;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int outstanding;
    int rtr_ej;
    // A1..A4 drain the four credits; B0 waits for a credit; D1..D5 fill the FIFO with no credits.
    tbl[0]  = mk(1, 32'hA1, 0, 0, 32'h00, 1);
    tbl[1]  = mk(1, 32'hA2, 0, 1, 32'hA1, 1);
    tbl[2]  = mk(1, 32'hA3, 0, 1, 32'hA2, 1);
    tbl[3]  = mk(1, 32'hA4, 0, 1, 32'hA3, 1);
    tbl[4]  = mk(1, 32'hB0, 0, 1, 32'hA4, 1);
    tbl[5]  = mk(0, 32'h00, 0, 0, 32'hA4, 1);
    tbl[6]  = mk(0, 32'h00, 0, 0, 32'hA4, 1);
    tbl[7]  = mk(0, 32'h00, 1, 0, 32'hA4, 1);
    tbl[8]  = mk(0, 32'h00, 0, 1, 32'hB0, 1);
    tbl[9]  = mk(0, 32'h00, 0, 0, 32'hB0, 1);
    tbl[10] = mk(1, 32'hD1, 0, 0, 32'hB0, 1);
    tbl[11] = mk(1, 32'hD2, 0, 0, 32'hB0, 1);
    tbl[12] = mk(1, 32'hD3, 0, 0, 32'hB0, 1);
    tbl[13] = mk(1, 32'hD4, 0, 0, 32'hB0, 0);
    tbl[14] = mk(1, 32'hD5, 1, 0, 32'hB0, 0);
    tbl[15] = mk(1, 32'hD5, 0, 1, 32'hD1, 1);
    tbl[16] = mk(1, 32'hD5, 0, 0, 32'hD1, 0);
    tbl[17] = mk(0, 32'h00, 0, 0, 32'hD1, 0);

    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk_reset("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].cv, tbl[i].cd, tbl[i].cr, 1'b0, '0, 1'b0);
      chk($sformatf("tbl%0d.inj_valid", i),  inj_valid_o,  tbl[i].e_v);
      chk($sformatf("tbl%0d.inj_flit", i),   inj_flit_o,   tbl[i].e_f);
      chk($sformatf("tbl%0d.core_ready", i), core_ready_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d.core_valid", i), core_valid_o, 0);
      chk($sformatf("tbl%0d.err", i),        err_o,        0);
    end

    // ---- ejection overflow, head retention and credit pulses ----
    do_reset("reset_ej");
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0, 1, 32'hC1 + i, 0);
      check_model("ej_fill");
    end
    cyc(0, '0, 0, 1, 32'hC5, 0);
    check_model("ej_over");
    chk("ej_over.err", err_o, 1);
    chk("ej_over.head", core_data_o, 32'hC1);
    dut_ejcr = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ej_drain%0d.head", i), core_data_o, 32'hC1 + i);
      cyc(0, '0, 0, 0, '0, 1);
      check_model("ej_drain");
      chk($sformatf("ej_drain%0d.credit", i), ej_credit_o, 1);
    end
    cyc(0, '0, 0, 0, '0, 1);
    check_model("ej_drained");
    chk("ej_drained.credit", ej_credit_o, 0);
    chk("ej_drained.pulses", dut_ejcr, 4);

    // ---- credit overflow and credit+send cancellation ----
    do_reset("reset_cred");
    cyc(0, '0, 1, 0, '0, 0);
    check_model("cred_over");
    chk("cred_over.err", err_o, 1);
    cyc(1, 32'hF1, 0, 0, '0, 0); check_model("cred_f1");
    cyc(1, 32'hF2, 0, 0, '0, 0); check_model("cred_f2");
    cyc(1, 32'hF3, 0, 0, '0, 0); check_model("cred_f3");
    cyc(0, '0, 1, 0, '0, 0);
    check_model("cred_cancel");
    chk("cred_cancel.flit", inj_flit_o, 32'hF3);
    dut_sends = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(i < 8, 32'hE0 + i, 0, 0, '0, 0);
      check_model("cred_left");
    end
    chk("cred_left.sends", dut_sends, 2);

    // ---- randomized, protocol-respecting traffic: err must stay low ----
    do_reset("reset_rand_a");
    outstanding = 0;
    rtr_ej = ED;
    for (int i = 0; i < 1500; i++) begin
      bit cr = (outstanding > 0) && ($urandom_range(0, 2) == 0);
      bit ev = (rtr_ej > 0) && ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 1) == 1, $urandom, cr, ev, $urandom, $urandom_range(0, 2) != 0);
      check_model("rand_a");
      outstanding = outstanding - int'(cr) + int'(m_inj_v);
      rtr_ej = rtr_ej - int'(ev) + int'(m_ejcr);
    end
    chk("rand_a.err", err_o, 0);

    // ---- randomized, unconstrained traffic including protocol errors ----
    do_reset("reset_rand_b");
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
      check_model("rand_b");
    end

    // ---- reset with traffic in flight ----
    do_reset("reset_mid_pre");
    for (int i = 0; i < 7; i++) begin
      cyc(1, 32'h70 + i, i == 6, i < 4, 32'h90 + i, i == 6);
      check_model("mid_fill");
    end
    do_reset("reset_mid");
    dut_sends = 0;
    dut_ejcr  = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, '0, 0, 0, '0, 1);
      check_model("after_rst");
    end
    chk("after_rst.sends", dut_sends, 0);
    chk("after_rst.ejcr", dut_ejcr, 0);
    cyc(1, 32'h5A, 0, 0, '0, 0); check_model("fresh_wr");
    cyc(0, '0, 0, 0, '0, 0);
    check_model("fresh_send");
    chk("fresh_send.flit", inj_flit_o, 32'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
